// File: rtl/frame_packer_if.sv
// Handshake bundle between frame_packer, the scope core (upstream) and the TX FIFO (downstream).
interface frame_packer_if;
  logic        i_frame_ready;
  logic [15:0] i_frame_size;
  logic [31:0] i_data;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] o_data;
  logic        o_vld;
  logic        i_rdy;
  logic        o_sop;
  logic        o_eop;
  logic        o_busy;
  logic        o_err_timeout;

  modport master (
    output i_frame_ready, i_frame_size, i_data, i_vld, i_rdy,
    input  o_rdy, o_data, o_vld, o_sop, o_eop, o_busy, o_err_timeout
  );

  modport slave (
    input  i_frame_ready, i_frame_size, i_data, i_vld, i_rdy,
    output o_rdy, o_data, o_vld, o_sop, o_eop, o_busy, o_err_timeout
  );
endinterface

// File: rtl/frame_packer.sv
// Packs one acquisition frame into header + payload (+ checksum trailer when FRAME_CSUM_EN is
// defined). Payload words pass through combinationally; stalled upstream is padded after a timeout.
module frame_packer #(
  parameter logic [15:0] SyncWord    = 16'hA55A,
  parameter int unsigned TimeoutCyc  = 4096,
  parameter logic [31:0] PadWord     = 32'hDEADDEAD,
  parameter logic [15:0] FrameCntRst = 16'h0000
) (
  input logic           clk,
  input logic           rst_n,
  frame_packer_if.slave bus
);
  localparam int unsigned ToW = $clog2(TimeoutCyc);

  typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StData, StPad, StTrl, StDone} state_e;

  state_e         state_q;
  logic [15:0]    frame_cnt_q, size_q, word_cnt_q;
  logic [ToW-1:0] to_cnt_q;
  logic           flag_to_q, err_q, vld_q, sop_q, eop_q;
  logic [31:0]    data_q, trl_word;
  logic           in_data, dn_xfer, up_xfer, data_last, timeout_hit;

`ifdef FRAME_CSUM_EN
  localparam bit CsumEn = 1'b1;
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == StIdle) begin
      csum_q <= '0;
    end else if (dn_xfer && (state_q != StTrl)) begin
      csum_q <= csum_q + bus.o_data;
    end
  end

  // Trailer folds in the word transferring this cycle so it is ready one cycle later.
  assign trl_word = '0 - (csum_q + bus.o_data);
`else
  localparam bit CsumEn = 1'b0;
  assign trl_word = '0;
`endif

  assign in_data     = (state_q == StData);
  assign data_last   = (word_cnt_q == size_q - 16'd1);
  assign timeout_hit = (to_cnt_q == ToW'(TimeoutCyc - 1));

  assign bus.o_vld         = in_data ? bus.i_vld  : vld_q;
  assign bus.o_data        = in_data ? bus.i_data : data_q;
  assign bus.o_sop         = in_data ? 1'b0 : sop_q;
  assign bus.o_eop         = in_data ? (~CsumEn && data_last) : eop_q;
  assign bus.o_rdy         = in_data ? bus.i_rdy : 1'b0;
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_err_timeout = err_q;

  assign dn_xfer = bus.o_vld && bus.i_rdy;
  assign up_xfer = bus.i_vld && bus.o_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= FrameCntRst;
      size_q      <= '0;
      word_cnt_q  <= '0;
      to_cnt_q    <= '0;
      flag_to_q   <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_frame_ready) begin
            size_q  <= bus.i_frame_size;
            state_q <= StHdr0;
            vld_q   <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            data_q  <= {SyncWord, frame_cnt_q};
          end
        end
        StHdr0: begin
          if (dn_xfer) begin
            state_q <= StHdr1;
            sop_q   <= 1'b0;
            data_q  <= {15'd0, flag_to_q, size_q};
            eop_q   <= ~CsumEn && (size_q == 16'd0);
          end
        end
        StHdr1: begin
          if (dn_xfer) begin
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            if (size_q != 16'd0) begin
              state_q <= StData;
              vld_q   <= 1'b0;
              eop_q   <= 1'b0;
            end else if (CsumEn) begin
              state_q <= StTrl;
              data_q  <= trl_word;
              eop_q   <= 1'b1;
            end else begin
              state_q <= StDone;
              vld_q   <= 1'b0;
              eop_q   <= 1'b0;
            end
          end
        end
        StData: begin
          if (up_xfer) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            to_cnt_q   <= '0;
            if (data_last && CsumEn) begin
              state_q <= StTrl;
              vld_q   <= 1'b1;
              data_q  <= trl_word;
              eop_q   <= 1'b1;
            end else if (data_last) begin
              state_q <= StDone;
            end
          end else if (!bus.i_vld) begin
            if (timeout_hit) begin
              state_q   <= StPad;
              err_q     <= 1'b1;
              flag_to_q <= 1'b1;
              vld_q     <= 1'b1;
              data_q    <= PadWord;
              eop_q     <= ~CsumEn && data_last;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        StPad: begin
          if (dn_xfer) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            if (data_last && CsumEn) begin
              state_q <= StTrl;
              data_q  <= trl_word;
              eop_q   <= 1'b1;
            end else if (data_last) begin
              state_q <= StDone;
              vld_q   <= 1'b0;
              eop_q   <= 1'b0;
            end else begin
              eop_q <= ~CsumEn && ((size_q - word_cnt_q) == 16'd2);
            end
          end
        end
        StTrl: begin
          if (dn_xfer) begin
            state_q <= StDone;
            vld_q   <= 1'b0;
            eop_q   <= 1'b0;
          end
        end
        StDone: begin
          flag_to_q <= 1'b0;
          // Count on exit so a held-high frame_ready bumps the counter exactly once.
          if (!bus.i_frame_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Randomized scoreboard bench for frame_packer: a packet model fills an expected-word queue and a
// negedge monitor pops and compares every downstream transfer.
module tb_frame_packer;
  localparam logic [15:0] FcRst = 16'hFFFF;
  localparam int unsigned ToCyc = 16;
  localparam logic [31:0] Pad   = 32'hDEADDEAD;
`ifdef FRAME_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  frame_packer_if bus ();

  frame_packer #(
    .SyncWord    (16'hA55A),
    .TimeoutCyc  (ToCyc),
    .PadWord     (Pad),
    .FrameCntRst (FcRst)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  word_t       exp_q[$];
  logic [31:0] up_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rdy_mode = 0;
  int          gap_pct = 0;
  logic [15:0] fc_m = FcRst;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] d, input logic s, input logic e);
    word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    exp_q.push_back(w);
  endfunction

  // Reference packet: header, supplied payload then pad words, optional negated-sum trailer.
  task automatic plan_frame(input int size, input int supply);
    logic [31:0] sum, w;
    sum = 32'd0;
    w = {16'hA55A, fc_m};
    push_exp(w, 1'b1, 1'b0);
    sum += w;
    w = {16'd0, 16'(size)};
    push_exp(w, 1'b0, !CsumEn && (size == 0));
    sum += w;
    for (int i = 0; i < size; i++) begin
      if (i < supply) begin
        w = $urandom;
        up_q.push_back(w);
      end else begin
        w = Pad;
      end
      push_exp(w, 1'b0, !CsumEn && (i == size - 1));
      sum += w;
    end
    if (CsumEn) push_exp(32'd0 - sum, 1'b0, 1'b1);
    fc_m = fc_m + 16'd1;
  endtask

  task automatic drive_frame(input int size, input int hold, input bit drop_early);
    int n;
    @(posedge clk); #2;
    bus.i_frame_ready = 1'b1;
    bus.i_frame_size  = 16'(size);
    n = 0;
    while (!bus.o_busy && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    check("busy_start", 32'(bus.o_busy), 32'd1);
    bus.i_frame_size = 16'($urandom);
    if (drop_early) bus.i_frame_ready = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check("pkt_done_left", 32'(exp_q.size()), 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("done_busy", 32'(bus.o_busy), 32'(!drop_early));
    check("done_quiet", 32'(bus.o_vld), 32'd0);
    @(posedge clk); #2;
    bus.i_frame_ready = 1'b0;
    n = 0;
    while (bus.o_busy && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    check("back_idle", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, 32'(bus.o_vld), 32'd0);
    check({tag, "_sop"}, 32'(bus.o_sop), 32'd0);
    check({tag, "_eop"}, 32'(bus.o_eop), 32'd0);
    check({tag, "_rdy"}, 32'(bus.o_rdy), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_err"}, 32'(bus.o_err_timeout), 32'd0);
    check({tag, "_data"}, bus.o_data, 32'd0);
  endtask

  // Upstream source and downstream ready generator.
  initial begin
    bit up_fire;
    bus.i_vld  = 1'b0;
    bus.i_data = 32'd0;
    bus.i_rdy  = 1'b0;
    forever begin
      @(negedge clk);
      up_fire = bus.i_vld && bus.o_rdy;
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.i_vld = 1'b0;
      end else begin
        if (up_fire && up_q.size() > 0) void'(up_q.pop_front());
        if (!(bus.i_vld && !up_fire)) begin
          if (up_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            bus.i_vld  = 1'b1;
            bus.i_data = up_q[0];
          end else begin
            bus.i_vld  = 1'b0;
            bus.i_data = $urandom;
          end
        end
      end
      case (rdy_mode)
        0:       bus.i_rdy = 1'b1;
        1:       bus.i_rdy = ~bus.i_rdy;
        default: bus.i_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every downstream transfer must match the head of the expected queue.
  initial begin
    word_t       e;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [1:0]  prev_flags;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_vld", 32'(bus.o_vld), 32'd1);
        check("stall_data", bus.o_data, prev_data);
        check("stall_flags", 32'({bus.o_sop, bus.o_eop}), 32'(prev_flags));
      end
      if (bus.o_vld && bus.i_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_word: got %h expected no transfer", bus.o_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", bus.o_data, e.data);
          check("word_sop", 32'(bus.o_sop), 32'(e.sop));
          check("word_eop", 32'(bus.o_eop), 32'(e.eop));
        end
      end
      prev_stall = bus.o_vld && !bus.i_rdy;
      prev_data  = bus.o_data;
      prev_flags = {bus.o_sop, bus.o_eop};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n, sz, hold;
    bit  drop;
    bus.i_frame_ready = 1'b0;
    bus.i_frame_size  = 16'd0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Counter starts at FFFF; next header must show the wrap to 0000.
    plan_frame(2, 2);
    drive_frame(2, 0, 1'b0);

    // Fixed frame: payload 1,2,3 at frame count 0.
    push_exp(32'hA55A0000, 1'b1, 1'b0);
    push_exp(32'h00000003, 1'b0, 1'b0);
    push_exp(32'h00000001, 1'b0, 1'b0);
    push_exp(32'h00000002, 1'b0, 1'b0);
    push_exp(32'h00000003, 1'b0, !CsumEn);
    if (CsumEn) push_exp(32'h5AA5FFF7, 1'b0, 1'b1);
    up_q.push_back(32'd1);
    up_q.push_back(32'd2);
    up_q.push_back(32'd3);
    fc_m = fc_m + 16'd1;
    drive_frame(3, 0, 1'b0);

    rdy_mode = 1;
    plan_frame(4, 4);
    drive_frame(4, 1, 1'b0);

    gap_pct = 25;
    for (int k = 0; k < 8; k++) begin
      rdy_mode = $urandom_range(0, 2);
      sz   = $urandom_range(0, 8);
      hold = $urandom_range(0, 5);
      drop = ($urandom_range(0, 2) == 0);
      if (drop) hold = hold + 2;
      plan_frame(sz, sz);
      drive_frame(sz, hold, drop);
    end

    // frame_ready held high long after the packet: no second packet.
    rdy_mode = 2;
    plan_frame(3, 3);
    drive_frame(3, 40, 1'b0);

    gap_pct  = 0;
    rdy_mode = 0;
    check("err_before_to", 32'(bus.o_err_timeout), 32'd0);
    plan_frame(5, 2);
    drive_frame(5, 0, 1'b0);
    check("err_after_to", 32'(bus.o_err_timeout), 32'd1);
    plan_frame(2, 2);
    drive_frame(2, 0, 1'b0);
    check("err_sticky", 32'(bus.o_err_timeout), 32'd1);

    // Reset while payload is flowing.
    plan_frame(6, 6);
    @(posedge clk); #2;
    bus.i_frame_ready = 1'b1;
    bus.i_frame_size  = 16'd6;
    n = 0;
    while (up_q.size() > 4 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_data_rdy", 32'(bus.o_rdy), 32'd1);
    rst_n = 1'b0;
    bus.i_frame_ready = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    up_q.delete();
    exp_q.delete();
    fc_m = FcRst;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    plan_frame(0, 0);
    drive_frame(0, 0, 1'b0);
    push_exp(32'hA55A0000, 1'b1, 1'b0);
    push_exp(32'h00000000, 1'b0, !CsumEn);
    if (CsumEn) push_exp(32'h5AA60000, 1'b0, 1'b1);
    fc_m = fc_m + 16'd1;
    drive_frame(0, 0, 1'b0);

    repeat (4) @(posedge clk);
    check("final_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
